// File: rtl/sc_regcointype_multi.sv
// ---------------------------------------------------------------------------
// sc_regcointype_multi
//
// W-bit coin/sprite type register for the game datapath and display logic.
// The held code can be loaded from an external bus, cleared to a fixed init
// value, or left to animate on its own by rotating or counting once every
// PRESCALE clock cycles.
//
// Parameters:
//   DATA_WIDTH              width W of the held code (W >= 1)
//   DATA_FIXED_INITREGCOIN  value applied by clear, truncated/zero-extended
//   PRESCALE                clock cycles per autonomous step (>= 1)
//
// Ports:
//   SC_RegCOINTYPE_CLOCK_50      system clock, rising edge
//   SC_RegCOINTYPE_RESET_InHigh  asynchronous active-high reset (REG=0)
//   SC_RegCOINTYPE_load_InLow    active-low synchronous load of data_In
//   SC_RegCOINTYPE_clear_InLow   active-low synchronous clear to init value
//   SC_RegCOINTYPE_mode_In       00 hold, 01 rotl, 10 rotr, 11 count-up
//   SC_RegCOINTYPE_data_In       value captured on load
//   SC_RegCOINTYPE_data_OutLow   current register contents
//   SC_RegCOINTYPE_tick_Out      high in the cycle an autonomous step is taken
//   SC_RegCOINTYPE_changed_Out   one-cycle pulse after the value changed
//
// Configuration macro:
//   SC_REGCOINTYPE_CHANGE_FLAG_EN  defined: change flag flop is built.
//                                  undefined: changed_Out tied low.
// ---------------------------------------------------------------------------
module sc_regcointype_multi #(
  parameter int DATA_WIDTH             = 4,
  parameter     DATA_FIXED_INITREGCOIN = 4'b0001,
  parameter int PRESCALE               = 8
) (
  input  logic                  SC_RegCOINTYPE_CLOCK_50,
  input  logic                  SC_RegCOINTYPE_RESET_InHigh,
  input  logic                  SC_RegCOINTYPE_load_InLow,
  input  logic                  SC_RegCOINTYPE_clear_InLow,
  input  logic [1:0]            SC_RegCOINTYPE_mode_In,
  input  logic [DATA_WIDTH-1:0] SC_RegCOINTYPE_data_In,
  output logic [DATA_WIDTH-1:0] SC_RegCOINTYPE_data_OutLow,
  output logic                  SC_RegCOINTYPE_tick_Out,
  output logic                  SC_RegCOINTYPE_changed_Out
);

  // The prescaler needs at least one bit even when PRESCALE is 1, in which
  // case it simply stays at zero and every non-hold edge is a step.
  localparam int CNT_WIDTH = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(PRESCALE - 1);
  localparam logic [DATA_WIDTH-1:0] INIT_CODE = DATA_WIDTH'(DATA_FIXED_INITREGCOIN);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_ROTL  = 2'b01;
  localparam logic [1:0] MODE_ROTR  = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  logic [DATA_WIDTH-1:0] regQ;
  logic [DATA_WIDTH-1:0] regNext;
  logic [DATA_WIDTH-1:0] stepValue;
  logic [DATA_WIDTH-1:0] rotLeft;
  logic [DATA_WIDTH-1:0] rotRight;
  logic [CNT_WIDTH-1:0]  cntQ;
  logic [CNT_WIDTH-1:0]  cntNext;
  logic                  stepNow;

  // A step is due when the register is free to animate (no load/clear this
  // cycle, not holding) and the prescaler has reached its last count. This
  // also drives tick_Out, so the tick marks exactly the cycle whose edge
  // applies the step.
  assign stepNow = (SC_RegCOINTYPE_mode_In != MODE_HOLD) && (cntQ == CNT_LAST) &&
                   SC_RegCOINTYPE_load_InLow && SC_RegCOINTYPE_clear_InLow;

  // Rotations are built bit by bit with modulo indexing so the same code
  // covers W=1, where both rotates collapse to the identity.
  always_comb begin
    rotLeft  = '0;
    rotRight = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rotLeft[i]  = regQ[(i + DATA_WIDTH - 1) % DATA_WIDTH];
      rotRight[i] = regQ[(i + 1) % DATA_WIDTH];
    end
  end

  // Select the value an autonomous step would produce in the current mode.
  // Count-up wraps naturally from all-ones to zero.
  always_comb begin
    stepValue = regQ;
    case (SC_RegCOINTYPE_mode_In)
      MODE_ROTL:  stepValue = rotLeft;
      MODE_ROTR:  stepValue = rotRight;
      MODE_COUNT: stepValue = regQ + 1'b1;
      default:    stepValue = regQ;
    endcase
  end

  // Next-state selection in priority order: load beats clear, clear beats
  // animation, and hold freezes both the code and the prescaler so an
  // interrupted interval resumes where it left off. Load and clear restart
  // the prescaler so the next step is a full interval away.
  always_comb begin
    regNext = regQ;
    cntNext = cntQ;
    if (!SC_RegCOINTYPE_load_InLow) begin
      regNext = SC_RegCOINTYPE_data_In;
      cntNext = '0;
    end else if (!SC_RegCOINTYPE_clear_InLow) begin
      regNext = INIT_CODE;
      cntNext = '0;
    end else if (SC_RegCOINTYPE_mode_In != MODE_HOLD) begin
      if (stepNow) begin
        regNext = stepValue;
        cntNext = '0;
      end else begin
        cntNext = cntQ + 1'b1;
      end
    end
  end

  // Code register and prescaler. Reset clears to zero rather than the init
  // value so a freshly reset datapath shows an empty code.
  always_ff @(posedge SC_RegCOINTYPE_CLOCK_50 or posedge SC_RegCOINTYPE_RESET_InHigh) begin
    if (SC_RegCOINTYPE_RESET_InHigh) begin
      regQ <= '0;
      cntQ <= '0;
    end else begin
      regQ <= regNext;
      cntQ <= cntNext;
    end
  end

`ifdef SC_REGCOINTYPE_CHANGE_FLAG_EN
  logic chgQ;

  // Change flag is registered alongside the code, so it rises in the same
  // cycle the new value appears. Reloading the held value leaves it low.
  always_ff @(posedge SC_RegCOINTYPE_CLOCK_50 or posedge SC_RegCOINTYPE_RESET_InHigh) begin
    if (SC_RegCOINTYPE_RESET_InHigh) begin
      chgQ <= 1'b0;
    end else begin
      chgQ <= (regNext != regQ);
    end
  end

  assign SC_RegCOINTYPE_changed_Out = chgQ;
`else
  assign SC_RegCOINTYPE_changed_Out = 1'b0;
`endif

  assign SC_RegCOINTYPE_data_OutLow = regQ;
  assign SC_RegCOINTYPE_tick_Out    = stepNow;

endmodule

// File: tb/tb_sc_regcointype_multi.sv
// ---------------------------------------------------------------------------
// tb_sc_regcointype_multi
//
// Bench for sc_regcointype_multi. Two instances share the same stimulus:
// one with PRESCALE=8 and one with PRESCALE=1, both 4 bits wide with the
// default init code of 1. A behavioural model tracks each instance.
// ---------------------------------------------------------------------------
module tb_sc_regcointype_multi;

`ifdef SC_REGCOINTYPE_CHANGE_FLAG_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       loadN;
  logic       clearN;
  logic [1:0] mode;
  logic [3:0] data;

  logic [3:0] q8, q1;
  logic       tick8, tick1, chg8, chg1;

  int total = 0;
  int bad   = 0;

  int mReg[2];
  int mCnt[2];
  bit mChg[2];
  int presc[2] = '{8, 1};

  typedef struct {
    logic       l;
    logic       c;
    logic [1:0] m;
    logic [3:0] d;
    logic [3:0] expQ;
    logic       expChg;
  } vec_t;

  vec_t vecs[7];

  always #5 clock = ~clock;

  sc_regcointype_multi #(.DATA_WIDTH(4), .DATA_FIXED_INITREGCOIN(4'b0001), .PRESCALE(8)) dut8 (
    .SC_RegCOINTYPE_CLOCK_50    (clock),
    .SC_RegCOINTYPE_RESET_InHigh(reset),
    .SC_RegCOINTYPE_load_InLow  (loadN),
    .SC_RegCOINTYPE_clear_InLow (clearN),
    .SC_RegCOINTYPE_mode_In     (mode),
    .SC_RegCOINTYPE_data_In     (data),
    .SC_RegCOINTYPE_data_OutLow (q8),
    .SC_RegCOINTYPE_tick_Out    (tick8),
    .SC_RegCOINTYPE_changed_Out (chg8)
  );

  sc_regcointype_multi #(.DATA_WIDTH(4), .DATA_FIXED_INITREGCOIN(4'b0001), .PRESCALE(1)) dut1 (
    .SC_RegCOINTYPE_CLOCK_50    (clock),
    .SC_RegCOINTYPE_RESET_InHigh(reset),
    .SC_RegCOINTYPE_load_InLow  (loadN),
    .SC_RegCOINTYPE_clear_InLow (clearN),
    .SC_RegCOINTYPE_mode_In     (mode),
    .SC_RegCOINTYPE_data_In     (data),
    .SC_RegCOINTYPE_data_OutLow (q1),
    .SC_RegCOINTYPE_tick_Out    (tick1),
    .SC_RegCOINTYPE_changed_Out (chg1)
  );

  // Value after one autonomous step, written as plain 4-bit arithmetic.
  function automatic int stepVal(int r, logic [1:0] m);
    case (m)
      2'b01:   return ((r << 1) | (r >> 3)) & 15;
      2'b10:   return ((r >> 1) | ((r & 1) << 3)) & 15;
      2'b11:   return (r + 1) % 16;
      default: return r;
    endcase
  endfunction

  function automatic bit expTick(int i);
    return (mode != 2'b00) && (mCnt[i] == presc[i] - 1) && loadN && clearN;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mReg[i] = 0;
      mCnt[i] = 0;
      mChg[i] = 1'b0;
    end
  endtask

  // Advance both models by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      int old;
      old = mReg[i];
      if (!loadN) begin
        mReg[i] = int'(data);
        mCnt[i] = 0;
      end else if (!clearN) begin
        mReg[i] = 1;
        mCnt[i] = 0;
      end else if (mode != 2'b00) begin
        if (mCnt[i] == presc[i] - 1) begin
          mCnt[i] = 0;
          mReg[i] = stepVal(mReg[i], mode);
        end else begin
          mCnt[i] = mCnt[i] + 1;
        end
      end
      mChg[i] = (mReg[i] != old);
    end
  endtask

  task automatic checkValue(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("q8",    int'(q8),    mReg[0]);
    checkValue("chg8",  int'(chg8),  int'(CHG_EN & mChg[0]));
    checkValue("tick8", int'(tick8), int'(expTick(0)));
    checkValue("q1",    int'(q1),    mReg[1]);
    checkValue("chg1",  int'(chg1),  int'(CHG_EN & mChg[1]));
    checkValue("tick1", int'(tick1), int'(expTick(1)));
  endtask

  // Drive inputs, check outputs against the model, then take one edge.
  task automatic applyStimulus(logic l, logic c, logic [1:0] m, logic [3:0] d);
    loadN  = l;
    clearN = c;
    mode   = m;
    data   = d;
    #1;
    checkOutput();
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  initial begin
    logic [3:0] rotrExp[4];

    vecs[0] = '{l: 1'b0, c: 1'b0, m: 2'b00, d: 4'h6, expQ: 4'h6, expChg: 1'b1};
    vecs[1] = '{l: 1'b1, c: 1'b0, m: 2'b00, d: 4'h0, expQ: 4'h1, expChg: 1'b1};
    vecs[2] = '{l: 1'b1, c: 1'b0, m: 2'b00, d: 4'h0, expQ: 4'h1, expChg: 1'b0};
    vecs[3] = '{l: 1'b0, c: 1'b1, m: 2'b00, d: 4'h1, expQ: 4'h1, expChg: 1'b0};
    vecs[4] = '{l: 1'b0, c: 1'b1, m: 2'b00, d: 4'hA, expQ: 4'hA, expChg: 1'b1};
    vecs[5] = '{l: 1'b0, c: 1'b1, m: 2'b11, d: 4'hF, expQ: 4'hF, expChg: 1'b1};
    vecs[6] = '{l: 1'b1, c: 1'b1, m: 2'b00, d: 4'h0, expQ: 4'hF, expChg: 1'b0};
    rotrExp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    // Power-on reset, checked without waiting for an edge.
    reset  = 1'b1;
    loadN  = 1'b1;
    clearN = 1'b1;
    mode   = 2'b00;
    data   = 4'h0;
    modelReset();
    #2;
    checkValue("rstQ8",   int'(q8),    0);
    checkValue("rstTick8", int'(tick8), 0);
    checkValue("rstChg8", int'(chg8),  0);
    checkValue("rstQ1",   int'(q1),    0);
    @(posedge clock);
    #2;
    reset = 1'b0;

    // Table: load/clear priority and change-flag behaviour.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k].l, vecs[k].c, vecs[k].m, vecs[k].d);
      checkValue($sformatf("tblQ8_%0d", k),   int'(q8),   int'(vecs[k].expQ));
      checkValue($sformatf("tblQ1_%0d", k),   int'(q1),   int'(vecs[k].expQ));
      checkValue($sformatf("tblChg8_%0d", k), int'(chg8), int'(CHG_EN & vecs[k].expChg));
    end

    // Rotate-left with PRESCALE=8: one step per 8 edges.
    applyStimulus(1'b0, 1'b1, 2'b00, 4'b1001);
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    checkValue("rolBefore", int'(q8), 4'b1001);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    checkValue("rolStep1", int'(q8), 4'b0011);
    checkValue("rolChg1",  int'(chg8), int'(CHG_EN));
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    checkValue("rolStep2", int'(q8), 4'b0110);

    // Hold freezes the prescaler mid-interval; resume needs 3 more edges.
    for (int k = 0; k < 5; k++)  applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 2'b00, 4'h0);
    checkValue("holdQ8", int'(q8), 4'b0110);
    for (int k = 0; k < 2; k++)  applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    checkValue("resumeEarly", int'(q8), 4'b0110);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    checkValue("resumeStep", int'(q8), 4'b1100);

    // A load while counting restarts the full interval.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'b0001);
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    checkValue("reloadWait", int'(q8), 4'b0001);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    checkValue("reloadStep", int'(q8), 4'b0010);

    // Count-up wrap from all-ones.
    applyStimulus(1'b0, 1'b1, 2'b00, 4'hF);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 2'b11, 4'h0);
    checkValue("wrapQ8",   int'(q8),   0);
    checkValue("wrapChg8", int'(chg8), int'(CHG_EN));
    applyStimulus(1'b1, 1'b1, 2'b00, 4'h0);
    checkValue("wrapChgEnd", int'(chg8), 0);

    // Rotate-right with PRESCALE=1: a step every edge, tick held high.
    applyStimulus(1'b0, 1'b1, 2'b00, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 4'h0);
      checkValue($sformatf("rorQ1_%0d", k),   int'(q1),    int'(rotrExp[k]));
      checkValue($sformatf("rorChg1_%0d", k), int'(chg1),  int'(CHG_EN));
      checkValue($sformatf("rorTick1_%0d", k), int'(tick1), 1);
    end

    // Asynchronous reset mid-count with the code at 4'hA.
    applyStimulus(1'b0, 1'b1, 2'b00, 4'hA);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 2'b01, 4'h0);
    checkValue("preRstQ8", int'(q8), 4'hA);
    #1;
    reset = 1'b1;
    modelReset();
    #1;
    checkValue("midRstQ8",    int'(q8),    0);
    checkValue("midRstTick8", int'(tick8), 0);
    checkValue("midRstChg8",  int'(chg8),  0);
    checkOutput();
    #1;
    reset = 1'b0;

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(logic'($urandom_range(0, 15) != 0),
                    logic'($urandom_range(0, 11) != 0),
                    2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)));
    end
    #1;
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
